// File: rtl/dmem_pipe_pkg.sv
// Shared encodings and field layouts for the load/store data memory.
package dmem_pipe_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    mem_size_e   size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        misalign;
  } mem_rsp_t;

  localparam logic CAUSE_RANGE    = 1'b0;
  localparam logic CAUSE_MISALIGN = 1'b1;

endpackage

// File: rtl/dmem_bank.sv
// Word-wide synchronous RAM with byte write enables and a read register
// that holds its value while the read enable is low.
module dmem_bank #(
  parameter int DEPTH_WORDS = 262144,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_pipe.sv
// Handshaked data memory: request decode and fault checks, lane steering,
// a one-deep response register and load extension.
module dmem_pipe
  import dmem_pipe_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          DEPTH_WORDS     = 262144,
  parameter bit          ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_misalign
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

  mem_req_t    req;
  mem_rsp_t    rsp;
  logic        accept;
  logic [31:0] offset;
  logic        f_size, f_range, f_mis, fault, cause;
  logic [3:0]  be, bank_we;
  logic [31:0] wlane, bank_rdata;
  logic        bank_re;

  logic        r_load, r_err, r_mis, r_uns;
  logic [1:0]  r_lane;
  mem_size_e   r_size;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext;

  assign req       = '{we: req_we, addr: req_addr, size: mem_size_e'(req_size),
                       is_unsigned: req_unsigned, wdata: req_wdata};
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign offset    = req.addr - BASE_ADDR;

  always_comb begin
    f_size  = (req.size == SZ_X);
    f_range = ({1'b0, offset} >= MEM_BYTES);
    f_mis   = ERR_ON_MISALIGN &&
              (((req.size == SZ_H) && req.addr[0]) ||
               ((req.size == SZ_W) && (req.addr[1:0] != 2'b00)));
    fault   = f_size || f_range || f_mis;
    cause   = (!f_size && !f_range && f_mis) ? CAUSE_MISALIGN : CAUSE_RANGE;
    be      = 4'b0000;
    wlane   = req.wdata;
    case (req.size)
      SZ_B: begin be = 4'b0001 << req.addr[1:0];          wlane = {4{req.wdata[7:0]}};  end
      SZ_H: begin be = 4'b0011 << {req.addr[1], 1'b0};    wlane = {2{req.wdata[15:0]}}; end
      SZ_W: begin be = 4'b1111;                           wlane = req.wdata;            end
      default: ;
    endcase
  end

  // A store caught by reset must not reach the RAM.
  assign bank_we = (accept && req.we && !fault && !rst) ? be : 4'b0000;
  assign bank_re = accept && !req.we;

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_bank (
    .clk   (clk),
    .re    (bank_re),
    .we    (bank_we),
    .addr  (offset[AW+1:2]),
    .wdata (wlane),
    .rdata (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      r_load    <= 1'b0;
      r_err     <= 1'b0;
      r_mis     <= 1'b0;
      r_uns     <= 1'b0;
      r_lane    <= 2'b00;
      r_size    <= SZ_W;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      r_load    <= !req.we && !fault;
      r_err     <= fault;
      r_mis     <= fault && cause;
      r_uns     <= req.is_unsigned;
      r_lane    <= req.addr[1:0];
      r_size    <= req.size;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_comb begin
    lane_b = bank_rdata[8*r_lane +: 8];
    lane_h = r_lane[1] ? bank_rdata[31:16] : bank_rdata[15:0];
    case (r_size)
      SZ_B:    ext = r_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_H:    ext = r_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: ext = bank_rdata;
    endcase
    rsp.rdata    = r_load ? ext : 32'h0;
    rsp.err      = r_err;
    rsp.misalign = r_mis;
  end

  assign rsp_rdata    = rsp.rdata;
  assign rsp_err      = rsp.err;
  assign rsp_misalign = rsp.misalign;

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed vector table plus streaming, stall and reset sequences.
module tb_dmem_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_misalign;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_pipe dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_misalign(rsp_misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input logic we, input logic [31:0] addr, input logic [1:0] size,
                   input logic uns, input logic [31:0] wdata, input logic [31:0] er,
                   input logic ee, input logic em);
    vec_t t;
    t = '{we, addr, size, uns, wdata, er, ee, em};
    vecs.push_back(t);
  endtask

  // One accepted request, response checked one cycle later.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_misalign", 32'(rsp_misalign), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset req_ready", 32'(req_ready), 32'd1);

    //  we  addr          sz  u  wdata          rdata        err mis
    v(1, 32'h100,      2, 0, 32'hDEADBEEF, 32'h0,        0, 0);
    v(0, 32'h100,      0, 0, 32'h0,        32'hFFFFFFEF, 0, 0);
    v(0, 32'h101,      0, 0, 32'h0,        32'hFFFFFFBE, 0, 0);
    v(0, 32'h102,      0, 0, 32'h0,        32'hFFFFFFAD, 0, 0);
    v(0, 32'h103,      0, 0, 32'h0,        32'hFFFFFFDE, 0, 0);
    v(0, 32'h101,      0, 1, 32'h0,        32'h000000BE, 0, 0);
    v(0, 32'h100,      2, 0, 32'h0,        32'hDEADBEEF, 0, 0);
    v(1, 32'h200,      2, 0, 32'h11223344, 32'h0,        0, 0);
    v(1, 32'h202,      1, 0, 32'hABCD8001, 32'h0,        0, 0);
    v(0, 32'h200,      2, 0, 32'h0,        32'h80013344, 0, 0);
    v(0, 32'h202,      1, 0, 32'h0,        32'hFFFF8001, 0, 0);
    v(0, 32'h202,      1, 1, 32'h0,        32'h00008001, 0, 0);
    v(0, 32'h200,      1, 1, 32'h0,        32'h00003344, 0, 0);
    v(0, 32'h201,      1, 0, 32'h0,        32'h0,        1, 1);
    v(0, 32'h103,      2, 0, 32'h0,        32'h0,        1, 1);
    v(1, 32'h102,      2, 0, 32'hCAFEF00D, 32'h0,        1, 1);
    v(0, 32'h100,      2, 0, 32'h0,        32'hDEADBEEF, 0, 0);
    v(1, 32'h100000,   2, 0, 32'h12345678, 32'h0,        1, 0);
    v(0, 32'h100000,   2, 0, 32'h0,        32'h0,        1, 0);
    v(0, 32'h100001,   2, 0, 32'h0,        32'h0,        1, 0);
    v(0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        1, 0);
    v(1, 32'h100,      3, 0, 32'h12345678, 32'h0,        1, 0);
    v(0, 32'h103,      3, 0, 32'h0,        32'h0,        1, 0);
    v(0, 32'h100,      2, 0, 32'h0,        32'hDEADBEEF, 0, 0);
    v(1, 32'hFFFFC,    2, 0, 32'h0BADF00D, 32'h0,        0, 0);
    v(0, 32'hFFFFC,    2, 0, 32'h0,        32'h0BADF00D, 0, 0);
    v(1, 32'h300,      2, 0, 32'h00000000, 32'h0,        0, 0);
    v(1, 32'h301,      0, 0, 32'h777777A5, 32'h0,        0, 0);
    v(0, 32'h300,      2, 0, 32'h0,        32'h0000A500, 0, 0);
    v(0, 32'h301,      0, 1, 32'h0,        32'h000000A5, 0, 0);
    v(0, 32'h301,      0, 0, 32'h0,        32'hFFFFFFA5, 0, 0);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata);
      chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("vec%0d rdata", i), rsp_rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
      if (vecs[i].exp_err)
        chk($sformatf("vec%0d misalign", i), 32'(rsp_misalign), 32'(vecs[i].exp_mis));
    end

    // Back-to-back stream of 8 loads.
    for (int i = 0; i < 8; i++) do_req(1'b1, 32'h500 + 32'(4*i), 2'd2, 1'b0, 32'h1000 + 32'(i));
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_addr = 32'h500 + 32'(4*i);
      @(posedge clk); #1;
      chk($sformatf("stream%0d valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("stream%0d rdata", i), rsp_rdata, 32'h1000 + 32'(i));
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream drained", 32'(rsp_valid), 32'd0);

    // Three-cycle consumer stall mid-stream.
    req_valid = 1'b1; req_addr = 32'h500;
    @(posedge clk); #1;
    req_addr = 32'h504; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("stall%0d req_ready", i), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("stall%0d rdata", i), rsp_rdata, 32'h1000);
    end
    rsp_ready = 1'b1;
    #1 chk("unstall req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("post-stall rdata1", rsp_rdata, 32'h1001);
    req_addr = 32'h508;
    @(posedge clk); #1;
    chk("post-stall rdata2", rsp_rdata, 32'h1002);
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("post-stall drained", 32'(rsp_valid), 32'd0);

    // Reset with a pending response and a store on offer.
    do_req(1'b1, 32'h600, 2'd2, 1'b0, 32'h55555555);
    do_req(1'b0, 32'h600, 2'd2, 1'b0, 32'h0);
    chk("pre-reset valid", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h600; req_size = 2'd2;
    req_wdata = 32'hAAAAAAAA; rsp_ready = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    chk("reset drop valid", 32'(rsp_valid), 32'd0);
    chk("reset drop rdata", rsp_rdata, 32'h0);
    do_req(1'b0, 32'h600, 2'd2, 1'b0, 32'h0);
    chk("reset suppressed store", rsp_rdata, 32'h55555555);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
